md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, 32, operand and HI/LO width in bits.
REQ-002 Parameter MULT_CYCLES, 5, multiply latency in cycles; legal range 1..255.
REQ-003 Parameter DIV_CYCLES, 10, divide latency in cycles; legal range 1..255.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous active-high reset.
REQ-006 Port start  input  1  qualifies op for one cycle.
REQ-007 Port op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 act as NONE.
REQ-008 Port a_rs  input  WIDTH  rs operand.
REQ-009 Port b_rt  input  WIDTH  rt operand.
REQ-010 Port rd_sel  input  1  read select: 0 LO, 1 HI.
REQ-011 Port rdata  output  WIDTH  combinational HI or LO per rd_sel.
REQ-012 Port busy  output  1  unit occupied; HI/LO reads and new ops must stall.
REQ-013 Port hi  output  WIDTH  HI register.
REQ-014 Port lo  output  WIDTH  LO register.

Function
REQ-015 States IDLE and RUN; an internal 8-bit counter is nonzero exactly in RUN.
REQ-016 In IDLE, start with a multiply-class op (MULT, MULTU, MADD*, MSUB*) latches a_rs/b_rt and op, loads counter with MULT_CYCLES and enters RUN.
REQ-017 In IDLE, start with DIV/DIVU latches operands, loads DIV_CYCLES and enters RUN.
REQ-018 In IDLE, start with MTHI/MTLO writes a_rs to HI/LO on that edge; no RUN entry.
REQ-019 In RUN, counter decrements every edge; on the 1->0 edge {HI,LO} is written with the result and the state returns to IDLE.
REQ-020 busy = (state==RUN) OR (start AND op is multiply-class or divide); combinational start term allows same-cycle stall.
REQ-021 busy is high for the start cycle plus exactly N following cycles (N = MULT_CYCLES or DIV_CYCLES); the result is visible on hi/lo in the first cycle with busy low.
REQ-022 start while in RUN is ignored for all ops, including MTHI/MTLO; HI/LO and the counter are unaffected.
REQ-023 MULT: {HI,LO} = signed 2*WIDTH-bit product; MULTU: unsigned product.
REQ-024 DIV: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign; DIVU: unsigned.
REQ-025 Divide by zero: LO = all ones, HI = dividend; busy timing unchanged.
REQ-026 Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
REQ-027 Back-to-back: start asserted in the first cycle with busy low is accepted normally.
REQ-028 Operands are sampled only at acceptance; a_rs/b_rt changes during RUN have no effect.

Reset
REQ-029 reset asserted at any time, including mid-RUN, forces IDLE, counter 0, HI 0, LO 0 and aborts the operation; busy falls to the value of its combinational start term.
REQ-030 The first edge after reset deassertion accepts start normally.

Configuration
REQ-031 Macro MD_MADD_EN defined: MADD/MADDU/MSUB/MSUBU perform {HI,LO} = {HI,LO} +/- signed/unsigned product, modulo 2^(2*WIDTH), written with MULT_CYCLES latency.
REQ-032 MD_MADD_EN undefined: ops 7-10 are treated as NONE; busy stays low and HI/LO are unchanged.

Verification
REQ-033 MULT a_rs=0xFFFFFFFE b_rt=0x00000003, default parameters -> busy high for 6 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA.
REQ-034 DIV a_rs=0xFFFFFFF9(-7) b_rt=2 -> busy high for 11 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF HI=7.
REQ-035 MULTU 0xFFFFFFFF*0xFFFFFFFF, then MTLO 0x1234 issued 2 cycles later -> MTLO ignored; HI=0xFFFFFFFE LO=0x00000001.
REQ-036 DIV started; reset pulsed at RUN cycle 4 -> busy low, HI=LO=0 immediately; a following MULT 3*4 -> LO=12 HI=0.
REQ-037 MD_MADD_EN defined: MTHI 0, MTLO 0xFFFFFFFF, MADDU 1*1 -> HI=1 LO=0; MD_MADD_EN undefined: same sequence -> busy never high, HI=0 LO=0xFFFFFFFF.
REQ-038 MULT_CYCLES=1, DIV_CYCLES=1 build: back-to-back MULT 2*3 then DIVU 7/2 accepted in the first busy-low cycle -> LO=6, then LO=3 HI=1; busy high 2 cycles each.

Source files
------------

// File: rtl/md_unit_if.sv
// md_unit_if: request/response bundle for the multiply/divide unit.
//   start, op, a_rs, b_rt, rd_sel : requester -> unit
//   rdata, busy, hi, lo           : unit -> requester
// Modports: master (requester side), slave (md_unit side).
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a_rs;
    logic [WIDTH-1:0] b_rt;
    logic             rd_sel;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_rs, b_rt, rd_sel,
        input  rdata, busy, hi, lo
    );

    modport slave (
        input  start, op, a_rs, b_rt, rd_sel,
        output rdata, busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset (clears state, counter, HI, LO)
//   bus    : md_unit_if.slave -- start/op/a_rs/b_rt/rd_sel in,
//            rdata/busy/hi/lo out
// Optional feature: define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (accumulate into {HI,LO}); without it ops 7-10 behave as NONE.
//
// state | meaning
// IDLE  | no operation in flight; accepts start, MTHI/MTLO write directly
// RUN   | multiply/divide in flight; counter counts down to the write-back
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic               start_mul, start_div;
    logic [2*WIDTH-1:0] prod_s, prod_u, result;
    logic [WIDTH-1:0]   quo, rem;
    logic signed [WIDTH-1:0] sa, sb;

    // Op classification of the incoming request.
    always_comb begin
        start_mul = 1'b0;
        start_div = 1'b0;
        case (bus.op)
            OP_MULT, OP_MULTU: start_mul = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU: start_div = 1'b1;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start && (start_mul || start_div)) state_nxt = RUN;
            RUN:  if (cnt == 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; the start term lets the requester stall in the issue cycle.
    always_comb begin
        bus.busy  = (state == RUN) || (bus.start && (start_mul || start_div));
        bus.rdata = bus.rd_sel ? hi_q : lo_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

    // Sign-extended operands give the signed product in the low 2*WIDTH bits.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign sa = a_q;
    assign sb = b_q;

    // Zero divisor and MOST_NEG/-1 are pinned explicitly so the result
    // never depends on the simulator or synthesis treatment of those cases.
    always_comb begin
        quo = '0;
        rem = '0;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end else if (op_q == OP_DIV) begin
            if (a_q == MOST_NEG && b_q == '1) begin
                quo = MOST_NEG;
                rem = '0;
            end else begin
                quo = sa / sb;
                rem = sa % sb;
            end
        end else begin
            quo = a_q / b_q;
            rem = a_q % b_q;
        end
    end

    always_comb begin
        result = {hi_q, lo_q};
        case (op_q)
            OP_MULT:          result = prod_s;
            OP_MULTU:         result = prod_u;
            OP_DIV, OP_DIVU:  result = {rem, quo};
`ifdef MD_MADD_EN
            OP_MADD:          result = {hi_q, lo_q} + prod_s;
            OP_MADDU:         result = {hi_q, lo_q} + prod_u;
            OP_MSUB:          result = {hi_q, lo_q} - prod_s;
            OP_MSUBU:         result = {hi_q, lo_q} - prod_u;
`endif
            default: ;
        endcase
    end

    // Datapath: operand capture, countdown, HI/LO write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= 8'd0;
            op_q <= 4'd0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                if (start_mul || start_div) begin
                    cnt  <= start_mul ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
                    op_q <= bus.op;
                    a_q  <= bus.a_rs;
                    b_q  <= bus.b_rt;
                end else if (bus.op == OP_MTHI) begin
                    hi_q <= bus.a_rs;
                end else if (bus.op == OP_MTLO) begin
                    lo_q <= bus.a_rs;
                end
            end
        end else begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) {hi_q, lo_q} <= result;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Main instance uses default latencies; a second instance runs with
// MULT_CYCLES=1 / DIV_CYCLES=1 for the back-to-back case.
// Inputs are driven and outputs sampled 1 time unit after the falling edge.
module tb_md_unit;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                           DIVU = 4'd4, MTHI = 4'd5, MTLO = 4'd6, MADDU = 4'd8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   n;

    md_unit_if #(.WIDTH(32)) m ();
    md_unit_if #(.WIDTH(32)) f ();

    md_unit #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (f.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one op on the main unit, count busy cycles, then check HI/LO.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        k = 0;
        m.start = 1'b1;
        m.op    = o;
        m.a_rs  = a;
        m.b_rt  = b;
        #1;
        while (m.busy && k < 300) begin
            k++;
            @(negedge clk);
            m.start = 1'b0;
            #1;
        end
        if (k == 0) begin
            @(negedge clk);
            m.start = 1'b0;
            #1;
        end
        m.start = 1'b0;
        check_val({tag, "_busy_cycles"}, 64'(k), 64'(exp_n));
        check_val({tag, "_hi"}, {32'd0, m.hi}, {32'd0, exp_hi});
        check_val({tag, "_lo"}, {32'd0, m.lo}, {32'd0, exp_lo});
    endtask

    // MTHI/MTLO: never raises busy, writes on the next edge.
    task automatic move_to(input logic [3:0] o, input logic [31:0] a);
        m.start = 1'b1;
        m.op    = o;
        m.a_rs  = a;
        #1;
        check_val("mt_busy", {63'd0, m.busy}, 64'd0);
        @(negedge clk);
        m.start = 1'b0;
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        m.start = 1'b0; m.op = NONE; m.a_rs = '0; m.b_rt = '0; m.rd_sel = 1'b0;
        f.start = 1'b0; f.op = NONE; f.a_rs = '0; f.b_rt = '0; f.rd_sel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_hi", {32'd0, m.hi}, 64'd0);
        check_val("rst_lo", {32'd0, m.lo}, 64'd0);
        check_val("rst_busy", {63'd0, m.busy}, 64'd0);
        check_val("rst_rdata", {32'd0, m.rdata}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        run_op("mult_neg", MULT, 32'hFFFF_FFFE, 32'h3, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        m.rd_sel = 1'b1; #1;
        check_val("rdata_hi", {32'd0, m.rdata}, 64'hFFFF_FFFF);
        m.rd_sel = 1'b0; #1;
        check_val("rdata_lo", {32'd0, m.rdata}, 64'hFFFF_FFFA);

        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", DIVU, 32'd7, 32'd0, 11, 32'd7, 32'hFFFF_FFFF);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 11, 32'd0, 32'h8000_0000);
        run_op("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, 11, 32'd1, 32'hFFFF_FFFD);
        run_op("div_zero_s", DIV, 32'hFFFF_FFF9, 32'd0, 11, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divu_big", DIVU, 32'hFFFF_FFF9, 32'd2, 11, 32'd1, 32'h7FFF_FFFC);

        // MULTU with an MTLO (and new operands) arriving mid-run.
        m.start = 1'b1; m.op = MULTU; m.a_rs = 32'hFFFF_FFFF; m.b_rt = 32'hFFFF_FFFF;
        @(negedge clk);
        m.start = 1'b0;
        @(negedge clk);
        m.start = 1'b1; m.op = MTLO; m.a_rs = 32'h1234; m.b_rt = 32'd5;
        #1;
        check_val("mtlo_in_run_busy", {63'd0, m.busy}, 64'd1);
        @(negedge clk);
        m.start = 1'b0;
        #1;
        n = 0;
        while (m.busy && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_val("multu_remaining", 64'(n), 64'd3);
        check_val("multu_hi", {32'd0, m.hi}, 64'hFFFF_FFFE);
        check_val("multu_lo", {32'd0, m.lo}, 64'h0000_0001);

        move_to(MTHI, 32'hAAAA);
        move_to(MTLO, 32'h5555);
        check_val("mthi", {32'd0, m.hi}, 64'hAAAA);
        check_val("mtlo", {32'd0, m.lo}, 64'h5555);
        run_op("op12_none", 4'd12, 32'd9, 32'd9, 0, 32'hAAAA, 32'h5555);

        // Reset in RUN cycle 4 of a divide.
        m.start = 1'b1; m.op = DIV; m.a_rs = 32'd100; m.b_rt = 32'd7;
        @(negedge clk);
        m.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("abort_busy", {63'd0, m.busy}, 64'd0);
        check_val("abort_hi", {32'd0, m.hi}, 64'd0);
        check_val("abort_lo", {32'd0, m.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        run_op("post_rst_mult", MULT, 32'd3, 32'd4, 6, 32'd0, 32'd12);

        move_to(MTHI, 32'd0);
        move_to(MTLO, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
        run_op("maddu", MADDU, 32'd1, 32'd1, 6, 32'd1, 32'd0);
`else
        run_op("maddu_off", MADDU, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif

        // Single-cycle latency instance, back-to-back issue.
        f.start = 1'b1; f.op = MULT; f.a_rs = 32'd2; f.b_rt = 32'd3;
        #1;
        n = 0;
        while (f.busy && n < 50) begin
            n++;
            @(negedge clk);
            f.start = 1'b0;
            #1;
        end
        check_val("fast_mult_busy", 64'(n), 64'd2);
        check_val("fast_mult_lo", {32'd0, f.lo}, 64'd6);
        f.start = 1'b1; f.op = DIVU; f.a_rs = 32'd7; f.b_rt = 32'd2;
        #1;
        n = 0;
        while (f.busy && n < 50) begin
            n++;
            @(negedge clk);
            f.start = 1'b0;
            #1;
        end
        check_val("fast_divu_busy", 64'(n), 64'd2);
        check_val("fast_divu_lo", {32'd0, f.lo}, 64'd3);
        check_val("fast_divu_hi", {32'd0, f.hi}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
